baw_card_tracker: RTL and testbench



---
 rtl/baw_pkg.sv | 29 ++
 rtl/baw_card_tracker_if.sv | 43 ++++
 rtl/baw_card_tracker_deck.sv | 87 ++++++++
 rtl/baw_card_tracker.sv | 59 +++++
 tb/tb_baw_card_tracker.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/baw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baw_pkg
// Description : Shared constants, result encoding and popcount helper for the
//               Black-and-White card tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package baw_pkg;

  localparam int          NUM_TILES  = 9;
  localparam logic [8:0]  FULL_DECK  = 9'h1FF;
  localparam logic [8:0]  BLACK_MASK = 9'b010101010;
  localparam logic [8:0]  WHITE_MASK = 9'b101010101;

  typedef enum logic [1:0] {
    RES_DRAW = 2'd0,
    RES_P1   = 2'd1,
    RES_P2   = 2'd2
  } res_e;

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_TILES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baw_card_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : baw_card_tracker_if
// Description : Strobe/select inputs and card/count/result outputs of the
//               card tracker, with master (game FSM side) and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface baw_card_tracker_if;
  logic [8:0] sel;
  logic       p1_commit;
  logic       p2_commit;
  logic       hand_clr;
  logic [8:0] p1_card;
  logic [8:0] p2_card;
  logic [3:0] p1_hand;
  logic [3:0] p2_hand;
  logic       p1_hand_valid;
  logic       p2_hand_valid;
  logic       p1_hand_is_black;
  logic       p2_hand_is_black;
  logic [3:0] p1_black;
  logic [3:0] p1_white;
  logic [3:0] p2_black;
  logic [3:0] p2_white;
  logic [1:0] match_result;
  logic       p1_err;
  logic       p2_err;

  modport master (
    output sel, p1_commit, p2_commit, hand_clr,
    input  p1_card, p2_card, p1_hand, p2_hand, p1_hand_valid, p2_hand_valid,
           p1_hand_is_black, p2_hand_is_black, p1_black, p1_white,
           p2_black, p2_white, match_result, p1_err, p2_err
  );

  modport slave (
    input  sel, p1_commit, p2_commit, hand_clr,
    output p1_card, p2_card, p1_hand, p2_hand, p1_hand_valid, p2_hand_valid,
           p1_hand_is_black, p2_hand_is_black, p1_black, p1_white,
           p2_black, p2_white, match_result, p1_err, p2_err
  );
endinterface
`default_nettype wire

// File: rtl/baw_card_tracker_deck.sv
`default_nettype none
// ============================================================================
// Module      : baw_player_deck
// Description : One player's card mask, committed hand and colour counts.
//               Optional select checking under BAW_SEL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module baw_player_deck
  import baw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] sel_i,
  input  logic       commit_i,
  input  logic       clr_i,
  output logic [8:0] card_o,
  output logic [3:0] hand_o,
  output logic       hand_valid_o,
  output logic       hand_is_black_o,
  output logic [3:0] black_o,
  output logic [3:0] white_o,
  output logic       err_o
);

  logic [8:0] card_q, card_d;
  logic [3:0] hand_q, hand_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [3:0] w_idx;
  logic       w_accept;

  always_comb begin
    // Descending scan so the lowest set bit is the last one written.
    w_idx = 4'd0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (sel_i[i]) w_idx = 4'(i);
    end
  end

`ifdef BAW_SEL_CHECK_EN
  logic w_onehot;
  logic w_ok;
  assign w_onehot = (sel_i != 9'd0) && ((sel_i & (sel_i - 9'd1)) == 9'd0);
  assign w_ok     = w_onehot && ((card_q & sel_i) != 9'd0);
  assign w_accept = commit_i && w_ok;
  assign err_d    = commit_i && !w_ok;
`else
  assign w_accept = commit_i;
  assign err_d    = 1'b0;
`endif

  always_comb begin
    card_d  = card_q;
    hand_d  = hand_q;
    valid_d = valid_q;
    if (clr_i) valid_d = 1'b0;
    if (w_accept) begin
      card_d  = card_q & ~sel_i;
      hand_d  = w_idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      card_q  <= FULL_DECK;
      hand_q  <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      card_q  <= card_d;
      hand_q  <= hand_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign card_o          = card_q;
  assign hand_o          = hand_q;
  assign hand_valid_o    = valid_q;
  assign hand_is_black_o = hand_q[0] & valid_q;
  assign black_o         = popcnt9(card_q & BLACK_MASK);
  assign white_o         = popcnt9(card_q & WHITE_MASK);
  assign err_o           = err_q;

endmodule
`default_nettype wire

// File: rtl/baw_card_tracker.sv
`default_nettype none
// ============================================================================
// Module      : baw_card_tracker
// Description : Two player decks plus the committed-tile comparator.
//               Optional select checking: BAW_SEL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module baw_card_tracker
  import baw_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  baw_card_tracker_if.slave        bus
);

  res_e w_res;

  baw_player_deck u_p1 (
    .clk             (clk),
    .reset           (reset),
    .sel_i           (bus.sel),
    .commit_i        (bus.p1_commit),
    .clr_i           (bus.hand_clr),
    .card_o          (bus.p1_card),
    .hand_o          (bus.p1_hand),
    .hand_valid_o    (bus.p1_hand_valid),
    .hand_is_black_o (bus.p1_hand_is_black),
    .black_o         (bus.p1_black),
    .white_o         (bus.p1_white),
    .err_o           (bus.p1_err)
  );

  baw_player_deck u_p2 (
    .clk             (clk),
    .reset           (reset),
    .sel_i           (bus.sel),
    .commit_i        (bus.p2_commit),
    .clr_i           (bus.hand_clr),
    .card_o          (bus.p2_card),
    .hand_o          (bus.p2_hand),
    .hand_valid_o    (bus.p2_hand_valid),
    .hand_is_black_o (bus.p2_hand_is_black),
    .black_o         (bus.p2_black),
    .white_o         (bus.p2_white),
    .err_o           (bus.p2_err)
  );

  always_comb begin
    w_res = RES_DRAW;
    if (bus.p1_hand_valid && bus.p2_hand_valid) begin
      if (bus.p1_hand > bus.p2_hand)      w_res = RES_P1;
      else if (bus.p2_hand > bus.p1_hand) w_res = RES_P2;
    end
  end

  assign bus.match_result = w_res;

endmodule
`default_nettype wire

// File: tb/tb_baw_card_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_baw_card_tracker
// Description : Directed plus randomized bench for baw_card_tracker against a
//               tile-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baw_card_tracker;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  baw_card_tracker_if bus ();

  baw_card_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: per player, which tiles are held, committed tile, flags.
  bit held [2][9];
  int m_hand [2];
  bit m_valid [2];
  bit m_err [2];

  function automatic logic [8:0] held_mask(input int p);
    logic [8:0] m;
    m = '0;
    for (int t = 0; t < 9; t++) if (held[p][t]) m[t] = 1'b1;
    return m;
  endfunction

  function automatic int colour_count(input int p, input bit want_black);
    int n;
    n = 0;
    for (int t = 0; t < 9; t++) if (held[p][t] && ((t % 2 == 1) == want_black)) n++;
    return n;
  endfunction

  function automatic int exp_match();
    if (!(m_valid[0] && m_valid[1])) return 0;
    if (m_hand[0] > m_hand[1]) return 1;
    if (m_hand[1] > m_hand[0]) return 2;
    return 0;
  endfunction

  task automatic model_edge(input bit r, input logic [8:0] s, input bit c1,
                            input bit c2, input bit clr);
    bit commit, ok;
    int ones, low;
    if (r) begin
      for (int p = 0; p < 2; p++) begin
        for (int t = 0; t < 9; t++) held[p][t] = 1'b1;
        m_hand[p] = 0; m_valid[p] = 0; m_err[p] = 0;
      end
      return;
    end
    ones = 0; low = -1;
    for (int t = 0; t < 9; t++) if (s[t]) begin ones++; if (low < 0) low = t; end
    if (low < 0) low = 0;
    for (int p = 0; p < 2; p++) begin
      commit = (p == 0) ? c1 : c2;
`ifdef BAW_SEL_CHECK_EN
      ok = (ones == 1) && held[p][low];
`else
      ok = 1'b1;
`endif
      m_err[p] = commit && !ok;
      if (commit && ok) begin
        for (int t = 0; t < 9; t++) if (s[t]) held[p][t] = 1'b0;
        m_hand[p] = low;
        m_valid[p] = 1'b1;
      end else if (clr) begin
        m_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("p1_card",   16'(bus.p1_card),          16'(held_mask(0)));
    chk("p2_card",   16'(bus.p2_card),          16'(held_mask(1)));
    chk("p1_hand",   16'(bus.p1_hand),          16'(m_hand[0]));
    chk("p2_hand",   16'(bus.p2_hand),          16'(m_hand[1]));
    chk("p1_valid",  16'(bus.p1_hand_valid),    16'(m_valid[0]));
    chk("p2_valid",  16'(bus.p2_hand_valid),    16'(m_valid[1]));
    chk("p1_isblk",  16'(bus.p1_hand_is_black), 16'(m_valid[0] && (m_hand[0] % 2 == 1)));
    chk("p2_isblk",  16'(bus.p2_hand_is_black), 16'(m_valid[1] && (m_hand[1] % 2 == 1)));
    chk("p1_black",  16'(bus.p1_black),         16'(colour_count(0, 1'b1)));
    chk("p1_white",  16'(bus.p1_white),         16'(colour_count(0, 1'b0)));
    chk("p2_black",  16'(bus.p2_black),         16'(colour_count(1, 1'b1)));
    chk("p2_white",  16'(bus.p2_white),         16'(colour_count(1, 1'b0)));
    chk("match",     16'(bus.match_result),     16'(exp_match()));
    chk("p1_err",    16'(bus.p1_err),           16'(m_err[0]));
    chk("p2_err",    16'(bus.p2_err),           16'(m_err[1]));
  endtask

  // Drive one cycle of inputs, advance model at the edge, check at negedge.
  task automatic cycle(input bit r, input logic [8:0] s, input bit c1,
                       input bit c2, input bit clr);
    reset = r; bus.sel = s; bus.p1_commit = c1; bus.p2_commit = c2; bus.hand_clr = clr;
    @(posedge clk);
    model_edge(r, s, c1, c2, clr);
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; bus.sel = '0; bus.p1_commit = 0; bus.p2_commit = 0; bus.hand_clr = 0;
    @(negedge clk);

    cycle(1, 9'h000, 0, 0, 0);
    chk("rst_p1_card", 16'(bus.p1_card), 16'h1FF);
    chk("rst_p2_card", 16'(bus.p2_card), 16'h1FF);
    chk("rst_black",   16'(bus.p1_black), 16'd4);
    chk("rst_white",   16'(bus.p2_white), 16'd5);
    chk("rst_match",   16'(bus.match_result), 16'd0);

    cycle(0, 9'h010, 1, 0, 0);
    chk("c4_card",  16'(bus.p1_card), 16'h1EF);
    chk("c4_hand",  16'(bus.p1_hand), 16'd4);
    chk("c4_white", 16'(bus.p1_white), 16'd4);
    chk("c4_blk",   16'(bus.p1_hand_is_black), 16'd0);
    chk("c4_match", 16'(bus.match_result), 16'd0);

    cycle(0, 9'h008, 0, 1, 0);
    chk("c3_hand",  16'(bus.p2_hand), 16'd3);
    chk("c3_black", 16'(bus.p2_black), 16'd3);
    chk("c3_match", 16'(bus.match_result), 16'd1);

    cycle(0, 9'h080, 1, 1, 0);
    chk("c7_h1",    16'(bus.p1_hand), 16'd7);
    chk("c7_h2",    16'(bus.p2_hand), 16'd7);
    chk("c7_blk",   16'({bus.p1_hand_is_black, bus.p2_hand_is_black}), 16'd3);
    chk("c7_match", 16'(bus.match_result), 16'd0);

`ifdef BAW_SEL_CHECK_EN
    cycle(0, 9'h010, 1, 0, 0);
    chk("rej4_err",  16'(bus.p1_err), 16'd1);
    chk("rej4_hand", 16'(bus.p1_hand), 16'd7);
    cycle(0, 9'h000, 0, 0, 0);
    chk("rej4_pulse", 16'(bus.p1_err), 16'd0);
    cycle(0, 9'h003, 1, 0, 0);
    chk("rej3_err",  16'(bus.p1_err), 16'd1);
`endif

    cycle(0, 9'h100, 0, 1, 1);
    chk("clr_v1",    16'(bus.p1_hand_valid), 16'd0);
    chk("clr_h2",    16'(bus.p2_hand), 16'd8);
    chk("clr_v2",    16'(bus.p2_hand_valid), 16'd1);
    chk("clr_match", 16'(bus.match_result), 16'd0);

    for (int t = 0; t < 9; t++) cycle(0, 9'(1 << t), 1, 0, 0);
    chk("all_card", 16'(bus.p1_card), 16'h000);
    cycle(1, 9'h001, 1, 1, 0);
    chk("rst_card",  16'(bus.p1_card), 16'h1FF);
    chk("rst_valid", 16'(bus.p1_hand_valid), 16'd0);

    for (int n = 0; n < 400; n++) begin
      logic [8:0] s;
      s = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
      cycle(($urandom_range(0, 49) == 0), s, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
